// File: rtl/isl58315_serial_sequencer.sv
// Serialises single register read/write commands into 16-bit 3-wire frames
// (sen_n / sclk / bidirectional sdio) for the ISL58315 laser-diode driver.
module isl58315_serial_sequencer #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned GAP_CYC = 8
) (
   input  logic       ACLK,
   input  logic       ARESETN,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic       sen_n,
   output logic       sclk,
   output logic       sdio_o,
   output logic       sdio_oe,
   input  logic       sdio_i
);

   localparam int unsigned HW = (CLK_DIV == 32'd0) ? 32'd1 : $clog2(CLK_DIV + 32'd1);
   localparam int unsigned GW = (GAP_CYC == 32'd0) ? 32'd1 : $clog2(GAP_CYC + 32'd1);
   localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 32'd1);
   localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 32'd1);
   localparam logic [HW-1:0] H_ONE  = HW'(32'd1);
   localparam logic [GW-1:0] G_ONE  = GW'(32'd1);

   if (CLK_DIV == 32'd0) begin : g_bad_clk_div
      $error("isl58315_serial_sequencer: CLK_DIV must be at least 1");
   end
   if (GAP_CYC == 32'd0) begin : g_bad_gap_cyc
      $error("isl58315_serial_sequencer: GAP_CYC must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t        state_r,     state_s;
   logic [HW-1:0] hcnt_r,      hcnt_s;
   logic [GW-1:0] gcnt_r,      gcnt_s;
   logic [3:0]    bit_r,       bit_s;
   logic [15:0]   shift_r,     shift_s;
   logic [7:0]    rx_r,        rx_s;
   logic          rw_r,        rw_s;
   logic          cmd_ready_r, cmd_ready_s;
   logic          busy_r,      busy_s;
   logic          rsp_valid_r, rsp_valid_s;
   logic [7:0]    rsp_rdata_r, rsp_rdata_s;
   logic          sen_n_r,     sen_n_s;
   logic          sclk_r,      sclk_s;
   logic          sdio_o_r,    sdio_o_s;
   logic          sdio_oe_r,   sdio_oe_s;
   logic          hcnt_last_s;
   logic          accept_s;

   assign hcnt_last_s = (hcnt_r == H_LAST);
   assign accept_s    = cmd_valid & cmd_ready_r;

   // Next-state and next-output logic; bit_r counts frame bits in transmit order
   // (0 = frame bit 15), and sclk_r doubles as the high/low phase flag in SHIFT.
   always_comb begin
      state_s     = state_r;
      hcnt_s      = hcnt_r;
      gcnt_s      = gcnt_r;
      bit_s       = bit_r;
      shift_s     = shift_r;
      rx_s        = rx_r;
      rw_s        = rw_r;
      cmd_ready_s = cmd_ready_r;
      rsp_valid_s = 1'b0;
      rsp_rdata_s = rsp_rdata_r;
      sen_n_s     = sen_n_r;
      sclk_s      = sclk_r;
      sdio_o_s    = sdio_o_r;
      sdio_oe_s   = sdio_oe_r;

      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s     = ST_SETUP;
               cmd_ready_s = 1'b0;
               rw_s        = cmd_rw;
               shift_s     = {cmd_rw, cmd_addr, (cmd_rw ? 8'h00 : cmd_wdata)};
               rx_s        = 8'h00;
               hcnt_s      = '0;
               sen_n_s     = 1'b0;
               sclk_s      = 1'b0;
               sdio_o_s    = cmd_rw;
               sdio_oe_s   = 1'b1;
            end else begin
               cmd_ready_s = 1'b1;
               sen_n_s     = 1'b1;
               sclk_s      = 1'b0;
               sdio_o_s    = 1'b0;
               sdio_oe_s   = 1'b0;
            end
         end

         ST_SETUP: begin
            if (hcnt_last_s) begin
               state_s = ST_SHIFT;
               hcnt_s  = '0;
               bit_s   = 4'd0;
               sclk_s  = 1'b1;
            end else begin
               hcnt_s  = hcnt_r + H_ONE;
            end
         end

         ST_SHIFT: begin
            if (!hcnt_last_s) begin
               hcnt_s = hcnt_r + H_ONE;
            end else if (sclk_r) begin
               // Last cycle of a high phase: capture read data, then fall and advance.
               hcnt_s   = '0;
               sclk_s   = 1'b0;
               shift_s  = {shift_r[14:0], 1'b0};
               sdio_o_s = shift_r[14];
               if (rw_r && bit_r[3]) begin
                  rx_s = {rx_r[6:0], sdio_i};
               end else begin
                  rx_s = rx_r;
               end
               if (rw_r && (bit_r == 4'd7)) begin
                  sdio_oe_s = 1'b0;
               end else begin
                  sdio_oe_s = sdio_oe_r;
               end
            end else if (bit_r == 4'd15) begin
               state_s     = ST_GAP;
               hcnt_s      = '0;
               gcnt_s      = '0;
               sen_n_s     = 1'b1;
               sdio_oe_s   = 1'b0;
               sdio_o_s    = 1'b0;
               rsp_valid_s = 1'b1;
               rsp_rdata_s = rw_r ? rx_r : 8'h00;
            end else begin
               hcnt_s = '0;
               bit_s  = bit_r + 4'd1;
               sclk_s = 1'b1;
            end
         end

         ST_GAP: begin
            if (gcnt_r == G_LAST) begin
               state_s     = ST_IDLE;
               cmd_ready_s = 1'b1;
            end else begin
               gcnt_s = gcnt_r + G_ONE;
            end
         end

         default: begin
            state_s     = ST_IDLE;
            cmd_ready_s = 1'b0;
            sen_n_s     = 1'b1;
            sclk_s      = 1'b0;
            sdio_o_s    = 1'b0;
            sdio_oe_s   = 1'b0;
         end
      endcase

      busy_s = ~cmd_ready_s;
   end

   // State and registered-output update; reset forces the pins idle at once.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_r     <= ST_IDLE;
         hcnt_r      <= '0;
         gcnt_r      <= '0;
         bit_r       <= 4'd0;
         shift_r     <= 16'h0000;
         rx_r        <= 8'h00;
         rw_r        <= 1'b0;
         cmd_ready_r <= 1'b0;
         busy_r      <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 8'h00;
         sen_n_r     <= 1'b1;
         sclk_r      <= 1'b0;
         sdio_o_r    <= 1'b0;
         sdio_oe_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         hcnt_r      <= hcnt_s;
         gcnt_r      <= gcnt_s;
         bit_r       <= bit_s;
         shift_r     <= shift_s;
         rx_r        <= rx_s;
         rw_r        <= rw_s;
         cmd_ready_r <= cmd_ready_s;
         busy_r      <= busy_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_rdata_r <= rsp_rdata_s;
         sen_n_r     <= sen_n_s;
         sclk_r      <= sclk_s;
         sdio_o_r    <= sdio_o_s;
         sdio_oe_r   <= sdio_oe_s;
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign busy      = busy_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign sen_n     = sen_n_r;
   assign sclk      = sclk_r;
   assign sdio_o    = sdio_o_r;
   assign sdio_oe   = sdio_oe_r;

endmodule
